// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and the
// two's-complement magnitude helper used when operands are latched.
package mdu_pkg;

    typedef enum logic [1:0] {
        EXE_MDU_MULT = 2'd0,
        EXE_MDU_DIV  = 2'd1,
        EXE_MDU_MTHI = 2'd2,
        EXE_MDU_MTLO = 2'd3
    } mdu_op_e;

    localparam logic [4:0] MDU_LAST_CNT = 5'd31;

    function automatic logic [31:0] mdu_mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_adder.sv
// N-bit adder/subtractor shared by the multiply add step (mode 0) and the
// divide trial subtraction (mode 1).
module mdu_adder #(
    parameter int N = 33
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         mode,
    output logic [N-1:0] sum
);

    assign sum = x + (mode ? ~y : y) + {{(N-1){1'b0}}, mode};

endmodule

// File: rtl/mdu.sv
// Iterative 32-bit multiply/divide unit owning HI/LO: 32 CALC cycles of
// shift-add or restoring division followed by one FIX cycle for the sign fix.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign,
    input  logic [1:0]  oper,
    input  logic        start,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        div_q, div_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic        divz_q, divz_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [63:0] acc_q, acc_d;

    logic [32:0] add_x, add_y, add_sum;
    logic [32:0] div_shift;
    logic        sa, sb;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // Multiply: acc high half plus multiplicand-or-zero. Divide: partial
    // remainder with the next dividend bit shifted in, minus the divisor.
    assign div_shift = {acc_q[63:32], opa_q[31]};
    assign add_x     = div_q ? div_shift : {1'b0, acc_q[63:32]};
    assign add_y     = div_q ? {1'b0, opb_q} : {1'b0, (opb_q[0] ? opa_q : 32'd0)};

    mdu_adder #(.N(33)) u_adder (
        .x    (add_x),
        .y    (add_y),
        .mode (div_q),
        .sum  (add_sum)
    );

    assign sa       = sign & a[31];
    assign sb       = sign & b[31];
    assign prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix  = (neg_q && !divz_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix  = (rneg_q && !divz_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        divz_d  = divz_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    case (mdu_op_e'(oper))
                        EXE_MDU_MTHI: hi_d = a;
                        EXE_MDU_MTLO: lo_d = a;
                        default: begin
                            div_d   = (mdu_op_e'(oper) == EXE_MDU_DIV);
                            divz_d  = (mdu_op_e'(oper) == EXE_MDU_DIV) && (b == 32'd0);
                            // Divide by zero keeps the raw dividend so HI comes back as a.
                            opa_d   = divz_d ? a : mdu_mag(a, sign);
                            opb_d   = mdu_mag(b, sign);
                            neg_d   = sa ^ sb;
                            rneg_d  = sa;
                            acc_d   = 64'd0;
                            cnt_d   = MDU_LAST_CNT;
                            busy_d  = 1'b1;
                            state_d = S_CALC;
                        end
                    endcase
                end
            end
            S_CALC: begin
                if (cancel) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (div_q) begin
                        acc_d[63:32] = add_sum[32] ? div_shift[31:0] : add_sum[31:0];
                        acc_d[31:0]  = {acc_q[30:0], ~add_sum[32]};
                        opa_d        = {opa_q[30:0], 1'b0};
                    end else begin
                        acc_d = {add_sum, acc_q[31:1]};
                        opb_d = {1'b0, opb_q[31:1]};
                    end
                    if (cnt_q == 5'd0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            S_FIX: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Datapath registers carry no reset; they are fully loaded on every start.
    always_ff @(posedge clk) begin
        div_q  <= div_d;
        neg_q  <= neg_d;
        rneg_q <= rneg_d;
        divz_q <= divz_d;
        cnt_q  <= cnt_d;
        opa_q  <= opa_d;
        opb_q  <= opb_d;
        acc_q  <= acc_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
